data_stack_unit: RTL and testbench

Parametrised, single-port data/stack memory for the five-stage pipeline's memory stage. It handles load/store at an explicit address and push/pop against an internal stack pointer. Each access is either a single word or a double word; a double word spans two consecutive memory words and takes two cycles. The block has a valid/ready request handshake, registered read data, and overflow/underflow error reporting.

---
 rtl/data_stack_pkg.sv | 31 +++
 rtl/sp_ram.sv | 21 ++
 rtl/data_stack_unit.sv | 159 +++++++++++++++
 tb/tb_data_stack_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared types for the memory-stage data/stack unit: opcodes, error codes, FSM states.
package data_stack_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  typedef enum logic {
    ERR_OVF = 1'b0,
    ERR_UNF = 1'b1
  } err_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  // Operations that return data on rd_data.
  function automatic logic op_is_read(op_e op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction

  // Operations that write the memory array.
  function automatic logic op_is_write(op_e op);
    return (op == OP_STORE) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port word memory with a registered read port; contents are never reset.
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write on the rising edge and register the word currently addressed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_stack_unit.sv
// Memory-stage data/stack unit: load/store at an address, push/pop against a
// downward-growing stack, single or double words, with overflow/underflow reporting.
// Double words always access the high half first and the low half in the second cycle.
module data_stack_unit
  import data_stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic                req_dbl,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rd_valid,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                err,
  output logic                err_code,
  output logic [ADDR_W-1:0]   sp,
  output logic [ADDR_W:0]     stk_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO_CNT   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A   = ADDR_W'(2);

  state_e              state_q, state_d;
  op_e                 op, op_q;
  logic                accept, ovf, unf;
  logic [ADDR_W:0]     need, free_words, cnt_q;
  logic [ADDR_W-1:0]   sp_w, sec_addr_d, sec_addr_q;
  logic                sec_we_q;
  logic [DATA_W-1:0]   wlo_q, hi_q, hi_sel;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic                rd_valid_q, rd_dbl_q, rd_zero_q, err_q;
  err_e                err_code_q;

  assign op         = op_e'(req_op);
  assign sp_w       = ADDR_W'(DEPTH-1) - cnt_q[ADDR_W-1:0];
  assign need       = req_dbl ? TWO_CNT : ONE_CNT;
  assign free_words = DEPTH_CNT - cnt_q;
  assign ovf        = (op == OP_PUSH) && (need > free_words);
  assign unf        = (op == OP_POP) && (need > cnt_q);
  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;

  assign sp       = sp_w;
  assign stk_cnt  = cnt_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign hi_sel   = rd_dbl_q ? hi_q : '0;
  assign rd_data  = (rd_valid_q && !rd_zero_q) ? {hi_sel, ram_rdata} : '0;

  sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // FSM state register; reset aborts any half-finished double access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus memory port steering for the first and second access.
  always_comb begin
    state_d    = state_q;
    ram_we     = 1'b0;
    ram_addr   = req_addr;
    ram_wdata  = req_dbl ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    sec_addr_d = req_addr + ONE_A;
    case (state_q)
      IDLE: begin
        case (op)
          OP_PUSH: begin
            ram_addr   = sp_w;
            sec_addr_d = sp_w - ONE_A;
          end
          OP_POP: begin
            ram_addr   = req_dbl ? (sp_w + TWO_A) : (sp_w + ONE_A);
            sec_addr_d = sp_w + ONE_A;
          end
          default: begin
            ram_addr   = req_addr;
            sec_addr_d = req_addr + ONE_A;
          end
        endcase
        ram_we = accept && ((op == OP_STORE) || ((op == OP_PUSH) && !ovf));
        if (accept && req_dbl && !ovf && !unf) state_d = SECOND;
      end
      SECOND: begin
        ram_addr  = sec_addr_q;
        ram_we    = sec_we_q;
        ram_wdata = wlo_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request bookkeeping, stack counter, read-result framing and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= OP_LOAD;
      sec_addr_q <= '0;
      sec_we_q   <= 1'b0;
      wlo_q      <= '0;
      hi_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_dbl_q   <= 1'b0;
      rd_zero_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_OVF;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == SECOND) begin
        hi_q       <= ram_rdata;
        rd_valid_q <= op_is_read(op_q);
        if (op_q == OP_PUSH)     cnt_q <= cnt_q + TWO_CNT;
        else if (op_q == OP_POP) cnt_q <= cnt_q - TWO_CNT;
      end else if (accept) begin
        op_q       <= op;
        sec_addr_q <= sec_addr_d;
        sec_we_q   <= op_is_write(op);
        wlo_q      <= req_wdata[DATA_W-1:0];
        rd_dbl_q   <= req_dbl;
        rd_zero_q  <= 1'b0;
        if (ovf) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_OVF;
        end else if (unf) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_UNF;
          rd_valid_q <= 1'b1;
          rd_zero_q  <= 1'b1;
        end else if (!req_dbl) begin
          rd_valid_q <= op_is_read(op);
          if (op == OP_PUSH)     cnt_q <= cnt_q + ONE_CNT;
          else if (op == OP_POP) cnt_q <= cnt_q - ONE_CNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_stack_unit.sv
// Self-checking bench for data_stack_unit: directed scenarios plus random ops
// compared against an atomic, word-array reference model of memory and stack.
module tb_data_stack_unit;
  import data_stack_pkg::*;

  localparam int DEPTH = 2048;
  localparam int MASK  = DEPTH - 1;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_dbl;
  logic [1:0]  req_op;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rd_valid, err, err_code;
  logic [31:0] rd_data;
  logic [10:0] sp;
  logic [11:0] stk_cnt;

  logic [15:0] mdl [DEPTH];
  int          mcnt;
  int          total;
  int          bad;

  data_stack_unit #(.DATA_W(16), .ADDR_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_dbl   (req_dbl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .err       (err),
    .err_code  (err_code),
    .sp        (sp),
    .stk_cnt   (stk_cnt)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run ever stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run still active, required finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: each request applied atomically to the word array and word count.
  task automatic modelOp(input logic [1:0] op, input logic dbl, input logic [10:0] a,
                         input logic [31:0] w, output logic eErr, output logic eCode,
                         output logic eRv, output logic [31:0] eData, output logic eTwo);
    int n, s, ai;
    n = dbl ? 2 : 1;
    s = (DEPTH - 1 - mcnt) & MASK;
    ai = int'(a);
    eErr = 1'b0; eCode = 1'b0; eRv = 1'b0; eData = '0; eTwo = 1'b0;
    case (op)
      OP_LOAD: begin
        eRv = 1'b1;
        eTwo = dbl;
        eData = dbl ? {mdl[ai], mdl[(ai + 1) & MASK]} : {16'h0, mdl[ai]};
      end
      OP_STORE: begin
        eTwo = dbl;
        if (dbl) begin
          mdl[ai] = w[31:16];
          mdl[(ai + 1) & MASK] = w[15:0];
        end else begin
          mdl[ai] = w[15:0];
        end
      end
      OP_PUSH: begin
        if (n > DEPTH - mcnt) begin
          eErr = 1'b1;
          eCode = 1'b0;
        end else begin
          eTwo = dbl;
          if (dbl) begin
            mdl[s] = w[31:16];
            mdl[(s - 1) & MASK] = w[15:0];
          end else begin
            mdl[s] = w[15:0];
          end
          mcnt += n;
        end
      end
      default: begin
        if (n > mcnt) begin
          eErr = 1'b1;
          eCode = 1'b1;
          eRv = 1'b1;
          eData = '0;
        end else begin
          eRv = 1'b1;
          eTwo = dbl;
          eData = dbl ? {mdl[(s + 2) & MASK], mdl[(s + 1) & MASK]} : {16'h0, mdl[(s + 1) & MASK]};
          mcnt -= n;
        end
      end
    endcase
  endtask

  // Issue one request (called just after a rising edge) and check its full outcome.
  task automatic applyStimulus(input logic [1:0] op, input logic dbl, input logic [10:0] a,
                               input logic [31:0] w);
    logic eErr, eCode, eRv, eTwo;
    logic [31:0] eData;
    int guard;
    guard = 0;
    while (!req_ready && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("readyBeforeReq", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_dbl = dbl; req_addr = a; req_wdata = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
    modelOp(op, dbl, a, w, eErr, eCode, eRv, eData, eTwo);
    if (eTwo) begin
      checkOutput("readyLowSecond", req_ready, 0);
      checkOutput("noEarlyValid", rd_valid, 0);
      checkOutput("noEarlyErr", err, 0);
      @(posedge clk); #1;
    end
    checkOutput("rdValid", rd_valid, eRv);
    if (eRv) checkOutput("rdData", rd_data, eData);
    checkOutput("err", err, eErr);
    if (eErr) checkOutput("errCode", err_code, eCode);
    checkOutput("stkCnt", stk_cnt, mcnt);
    checkOutput("sp", sp, (DEPTH - 1 - mcnt) & MASK);
    checkOutput("readyAfter", req_ready, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rstReady", req_ready, 1);
    checkOutput("rstRdValid", rd_valid, 0);
    checkOutput("rstRdData", rd_data, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstErrCode", err_code, 0);
    checkOutput("rstStkCnt", stk_cnt, 0);
    checkOutput("rstSp", sp, DEPTH - 1);
  endtask

  // Main sequence: reset, directed scenarios, stack fill/overflow, reset mid-op, random traffic.
  initial begin
    int s;
    logic [1:0]  rOp;
    logic        rDbl;
    logic [10:0] rAddr;
    total = 0; bad = 0; mcnt = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_dbl = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(OP_STORE, 1'b0, 11'd5, 32'h0000_1234);
    applyStimulus(OP_LOAD, 1'b0, 11'd5, 32'h0);
    applyStimulus(OP_STORE, 1'b1, 11'(DEPTH - 1), 32'hAAAA_5555);
    applyStimulus(OP_LOAD, 1'b1, 11'(DEPTH - 1), 32'h0);
    applyStimulus(OP_LOAD, 1'b0, 11'(DEPTH - 1), 32'h0);
    applyStimulus(OP_LOAD, 1'b0, 11'd0, 32'h0);

    applyStimulus(OP_PUSH, 1'b0, 11'd0, 32'h0000_0011);
    applyStimulus(OP_PUSH, 1'b1, 11'd0, 32'h2222_3333);
    applyStimulus(OP_POP, 1'b1, 11'd0, 32'h0);
    applyStimulus(OP_POP, 1'b0, 11'd0, 32'h0);
    applyStimulus(OP_POP, 1'b0, 11'd0, 32'h0);
    applyStimulus(OP_POP, 1'b1, 11'd0, 32'h0);

    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(OP_PUSH, 1'b0, 11'd0, 32'(i) ^ 32'h5A00);
    applyStimulus(OP_PUSH, 1'b1, 11'd0, 32'hDEAD_BEEF);
    applyStimulus(OP_PUSH, 1'b0, 11'd0, 32'h0000_7777);
    applyStimulus(OP_PUSH, 1'b0, 11'd0, 32'h0000_8888);
    applyStimulus(OP_POP, 1'b1, 11'd0, 32'h0);
    applyStimulus(OP_POP, 1'b0, 11'd0, 32'h0);
    applyStimulus(OP_POP, 1'b0, 11'd0, 32'h0);

    req_valid = 1'b1; req_op = OP_PUSH; req_dbl = 1'b1; req_addr = '0; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("inSecondBeforeReset", req_ready, 0);
    s = (DEPTH - 1 - mcnt) & MASK;
    mdl[s] = 16'hCAFE;
    mcnt = 0;
    rst_n = 1'b0;
    #1;
    checkResetState();
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(OP_PUSH, 1'b0, 11'd0, 32'h0000_0055);
    applyStimulus(OP_POP, 1'b0, 11'd0, 32'h0);
    applyStimulus(OP_LOAD, 1'b0, 11'(s), 32'h0);
    applyStimulus(OP_STORE, 1'b0, 11'd3, 32'h0000_0BEE);
    applyStimulus(OP_LOAD, 1'b0, 11'd3, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rOp  = 2'($urandom_range(0, 3));
      rDbl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) rAddr = 11'($urandom_range(0, 7));
      else                           rAddr = 11'(DEPTH - 1 - $urandom_range(0, 7));
      applyStimulus(rOp, rDbl, rAddr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
